// File: rtl/sccb_write_master_if.sv
// -----------------------------------------------------------------------------
// sccb_write_master_if
//  Request / pad-control bundle for sccb_write_master.
//  master modport : seen from the write master (requests in, pad enables out)
//  slave modport  : seen from the requester / pad side
//  Signals:
//   start     request strobe, accepted only while busy=0
//   dev_addr  7-bit slave address (R/W bit is always 0)
//   reg_addr  register address byte
//   wr_data   register data byte
//   sda_in    synchronised SDA pad level, used for ACK sampling
//   scl_oe    1 = pull SCL low
//   sda_oe    1 = pull SDA low
//   busy      transaction in progress
//   done      one-cycle pulse at the end of every transaction
//   ack_err   sticky NACK flag, cleared when the next request is accepted
// -----------------------------------------------------------------------------
interface sccb_write_master_if;
   logic       start;
   logic [6:0] dev_addr;
   logic [7:0] reg_addr;
   logic [7:0] wr_data;
   logic       sda_in;
   logic       scl_oe;
   logic       sda_oe;
   logic       busy;
   logic       done;
   logic       ack_err;

   modport master (
      input  start,
      input  dev_addr,
      input  reg_addr,
      input  wr_data,
      input  sda_in,
      output scl_oe,
      output sda_oe,
      output busy,
      output done,
      output ack_err
   );

   modport slave (
      output start,
      output dev_addr,
      output reg_addr,
      output wr_data,
      output sda_in,
      input  scl_oe,
      input  sda_oe,
      input  busy,
      input  done,
      input  ack_err
   );
endinterface

// File: rtl/sccb_write_master.sv
// -----------------------------------------------------------------------------
// sccb_write_master
//  Performs one 3-phase SCCB/I2C register write per request:
//  START, {dev_addr,W}, ACK, reg_addr, ACK, wr_data, ACK, STOP.
//  Every protocol step is paced by the 400 kHz tick strobe, four ticks per
//  SCL bit, so SCL runs at 100 kHz. The pads are open drain: the block only
//  ever pulls a line low (oe=1) or releases it (oe=0).
//  Ports:
//   clk     system clock
//   reset   asynchronous, active-high reset; releases both lines at once
//   tick    one-cycle pacing strobe
//   bus     sccb_write_master_if.master (request, pad enables, status)
//  Parameter:
//   IGNORE_NACK  1: ACK slots are don't-care (SCCB style)
//                0: a NACK aborts to STOP and raises ack_err
// -----------------------------------------------------------------------------
module sccb_write_master #(
   parameter bit IGNORE_NACK = 1'b0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        tick,
   sccb_write_master_if.master         bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_BIT,
      S_ACK,
      S_STOP,
      S_DONE
   } state_t;

   state_t      state_reg;
   logic [1:0]  phase_reg;
   logic [23:0] shift_reg;
   logic [2:0]  bit_cnt_reg;
   logic [1:0]  byte_cnt_reg;
   logic        ack_sample_reg;
   logic        scl_oe_reg;
   logic        sda_oe_reg;
   logic        busy_reg;
   logic        done_reg;
   logic        ack_err_reg;

   assign bus.scl_oe  = scl_oe_reg;
   assign bus.sda_oe  = sda_oe_reg;
   assign bus.busy    = busy_reg;
   assign bus.done    = done_reg;
   assign bus.ack_err = ack_err_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= S_IDLE;
         phase_reg      <= 2'd0;
         shift_reg      <= 24'd0;
         bit_cnt_reg    <= 3'd0;
         byte_cnt_reg   <= 2'd0;
         ack_sample_reg <= 1'b0;
         scl_oe_reg     <= 1'b0;
         sda_oe_reg     <= 1'b0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         ack_err_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;

         case (state_reg)
            S_IDLE: begin
               scl_oe_reg <= 1'b0;
               sda_oe_reg <= 1'b0;
               // The done cycle is the tail of the previous transaction, so
               // a request arriving together with done is not taken.
               if (bus.start && !done_reg) begin
                  shift_reg    <= {bus.dev_addr, 1'b0, bus.reg_addr, bus.wr_data};
                  busy_reg     <= 1'b1;
                  ack_err_reg  <= 1'b0;
                  bit_cnt_reg  <= 3'd0;
                  byte_cnt_reg <= 2'd0;
                  phase_reg    <= 2'd0;
                  state_reg    <= S_START;
                  // A tick in this cycle is deliberately not consumed.
               end
            end

            S_START: begin
               if (tick) begin
                  case (phase_reg)
                     2'd0: begin
                        scl_oe_reg <= 1'b0;
                        sda_oe_reg <= 1'b0;
                        phase_reg  <= 2'd1;
                     end
                     2'd1: begin
                        // SDA falls while SCL is high: START condition.
                        sda_oe_reg <= 1'b1;
                        phase_reg  <= 2'd2;
                     end
                     default: begin
                        scl_oe_reg <= 1'b1;
                        phase_reg  <= 2'd0;
                        state_reg  <= S_BIT;
                     end
                  endcase
               end
            end

            S_BIT: begin
               if (tick) begin
                  case (phase_reg)
                     2'd0: begin
                        // SCL is already low here, so SDA may change.
                        scl_oe_reg <= 1'b1;
                        sda_oe_reg <= ~shift_reg[23];
                        phase_reg  <= 2'd1;
                     end
                     2'd1: begin
                        scl_oe_reg <= 1'b0;
                        phase_reg  <= 2'd2;
                     end
                     2'd2: begin
                        phase_reg  <= 2'd3;
                     end
                     default: begin
                        scl_oe_reg  <= 1'b1;
                        shift_reg   <= {shift_reg[22:0], 1'b0};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        phase_reg   <= 2'd0;
                        if (bit_cnt_reg == 3'd7) begin
                           state_reg <= S_ACK;
                        end
                     end
                  endcase
               end
            end

            S_ACK: begin
               if (tick) begin
                  case (phase_reg)
                     2'd0: begin
                        // Release SDA so the slave can drive the ACK bit.
                        scl_oe_reg <= 1'b1;
                        sda_oe_reg <= 1'b0;
                        phase_reg  <= 2'd1;
                     end
                     2'd1: begin
                        scl_oe_reg <= 1'b0;
                        phase_reg  <= 2'd2;
                     end
                     2'd2: begin
                        // Mid-way through the SCL high time.
                        ack_sample_reg <= bus.sda_in;
                        phase_reg      <= 2'd3;
                     end
                     default: begin
                        scl_oe_reg <= 1'b1;
                        phase_reg  <= 2'd0;
                        if (ack_sample_reg && !IGNORE_NACK) begin
                           ack_err_reg <= 1'b1;
                           state_reg   <= S_STOP;
                        end else if (byte_cnt_reg == 2'd2) begin
                           state_reg <= S_STOP;
                        end else begin
                           byte_cnt_reg <= byte_cnt_reg + 2'd1;
                           state_reg    <= S_BIT;
                        end
                     end
                  endcase
               end
            end

            S_STOP: begin
               if (tick) begin
                  case (phase_reg)
                     2'd0: begin
                        // Park SDA low under a low SCL before the STOP edge.
                        scl_oe_reg <= 1'b1;
                        sda_oe_reg <= 1'b1;
                        phase_reg  <= 2'd1;
                     end
                     2'd1: begin
                        scl_oe_reg <= 1'b0;
                        phase_reg  <= 2'd2;
                     end
                     default: begin
                        // SDA rises while SCL is high: STOP condition.
                        sda_oe_reg <= 1'b0;
                        phase_reg  <= 2'd0;
                        state_reg  <= S_DONE;
                     end
                  endcase
               end
            end

            S_DONE: begin
               done_reg   <= 1'b1;
               busy_reg   <= 1'b0;
               scl_oe_reg <= 1'b0;
               sda_oe_reg <= 1'b0;
               phase_reg  <= 2'd0;
               state_reg  <= S_IDLE;
            end

            default: begin
               scl_oe_reg <= 1'b0;
               sda_oe_reg <= 1'b0;
               busy_reg   <= 1'b0;
               phase_reg  <= 2'd0;
               state_reg  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sccb_write_master.sv
// -----------------------------------------------------------------------------
// tb_sccb_write_master
//  Directed bench for sccb_write_master. Two instances share stimulus: u0
//  aborts on NACK, u1 ignores NACK; sel chooses which one receives start and
//  which one the bus monitor / slave model watch.
// -----------------------------------------------------------------------------
module tb_sccb_write_master;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0;
   logic       start = 1'b0;
   logic       sel = 1'b0;
   logic [6:0] dev = 7'd0;
   logic [7:0] rega = 8'd0;
   logic [7:0] data = 8'd0;
   logic       sda_in = 1'b1;
   logic [1:0] tick_div = 2'd0;
   logic [2:0] ack_mask = 3'b111;

   int checks = 0;
   int errors = 0;

   sccb_write_master_if if0 ();
   sccb_write_master_if if1 ();

   assign if0.start    = start & ~sel;
   assign if1.start    = start & sel;
   assign if0.dev_addr = dev;
   assign if1.dev_addr = dev;
   assign if0.reg_addr = rega;
   assign if1.reg_addr = rega;
   assign if0.wr_data  = data;
   assign if1.wr_data  = data;
   assign if0.sda_in   = sda_in;
   assign if1.sda_in   = sda_in;

   sccb_write_master #(.IGNORE_NACK(1'b0)) u0 (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .bus   (if0)
   );

   sccb_write_master #(.IGNORE_NACK(1'b1)) u1 (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .bus   (if1)
   );

   logic m_scl, m_sda, m_busy, m_done, m_err;
   assign m_scl  = sel ? if1.scl_oe  : if0.scl_oe;
   assign m_sda  = sel ? if1.sda_oe  : if0.sda_oe;
   assign m_busy = sel ? if1.busy    : if0.busy;
   assign m_done = sel ? if1.done    : if0.done;
   assign m_err  = sel ? if1.ack_err : if0.ack_err;

   always #5 clk = ~clk;

   // One tick every fourth clock, changed on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         tick = (tick_div == 2'd3);
         tick_div = tick_div + 2'd1;
      end
   end

   // Bus monitor + slave model, evaluated 1 time unit after each rising edge.
   int cyc = 0, tick_cnt = 0, last_tick_cyc = 0, done_cyc = 0, done_ticks = 0;
   int done_count = 0, fall_cnt = 0, bit_idx = 0, n_start = 0, n_stop = 0;
   int last_edge_tick = -1, min_iv = 1000, max_iv = 0;
   logic [0:31] bitv = '0;
   logic prev_busy = 1'b0, prev_scl = 1'b0, prev_sda = 1'b0;
   logic slave_pull;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (!prev_busy && m_busy) begin
            tick_cnt = 0; fall_cnt = 0; bit_idx = 0; bitv = '0;
            n_start = 0; n_stop = 0; last_edge_tick = -1;
            min_iv = 1000; max_iv = 0;
         end else if (prev_busy && tick && !m_done) begin
            tick_cnt++;
            last_tick_cyc = cyc;
         end
         if (m_done) begin
            done_count++;
            done_cyc = cyc;
            done_ticks = tick_cnt;
         end
         if (m_scl != prev_scl) begin
            if (last_edge_tick >= 0) begin
               if (tick_cnt - last_edge_tick < min_iv) min_iv = tick_cnt - last_edge_tick;
               if (tick_cnt - last_edge_tick > max_iv) max_iv = tick_cnt - last_edge_tick;
            end
            last_edge_tick = tick_cnt;
            if (m_scl) begin
               fall_cnt++;
            end else if (bit_idx < 32) begin
               bitv[bit_idx] = ~m_sda;
               bit_idx++;
            end
         end else if (!m_scl && (m_sda != prev_sda)) begin
            if (m_sda) n_start++;
            else n_stop++;
         end
         prev_busy = m_busy;
         prev_scl  = m_scl;
         prev_sda  = m_sda;
         // Slave pulls SDA low between the 8th and 9th SCL fall of a byte.
         slave_pull = (fall_cnt > 0) && (fall_cnt % 9 == 0) && (fall_cnt <= 27)
                      && ack_mask[fall_cnt / 9 - 1];
         sda_in = ~(m_sda | slave_pull);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] get_byte(input int base);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[7-i] = bitv[base+i];
      return b;
   endfunction

   task automatic run_start(input logic [6:0] d, input logic [7:0] r,
                            input logic [7:0] w, input bit align);
      @(posedge clk); #2;
      if (align) begin
         while (tick_div != 2'd3) begin
            @(posedge clk); #2;
         end
      end
      dev = d; rega = r; data = w; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      int dc;
      dc = done_count;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #2;
         if (done_count != dc) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #2;
      checks++; if (if0.scl_oe !== 1'b0) begin errors++; $display("FAIL reset_scl_oe got %b want 0", if0.scl_oe); end
      checks++; if (if0.sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got %b want 0", if0.sda_oe); end
      checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", if0.busy); end
      checks++; if (if0.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", if0.done); end
      checks++; if (if0.ack_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err got %b want 0", if0.ack_err); end
      checks++; if (if1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_u1 got %b want 0", if1.busy); end
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", if0.busy); end
      $display("test_reset done");
   endtask

   task automatic test_write();
      bit ok;
      sel = 1'b0; ack_mask = 3'b111;
      // start coincides with a tick: that tick must not be consumed
      run_start(7'h21, 8'h12, 8'h80, 1'b1);
      checks++; if (m_busy !== 1'b1) begin errors++; $display("FAIL write_busy_after_accept got %b want 1", m_busy); end
      wait_done(2000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL write_timeout got no done want done"); end
      checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL write_busy_with_done got %b want 0", m_busy); end
      checks++; if (done_ticks != 114) begin errors++; $display("FAIL write_ticks got %0d want 114", done_ticks); end
      checks++; if (done_cyc - last_tick_cyc != 1) begin errors++; $display("FAIL write_done_lag got %0d want 1", done_cyc - last_tick_cyc); end
      checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL write_ack_err got %b want 0", m_err); end
      checks++; if (get_byte(0) !== 8'h42) begin errors++; $display("FAIL write_byte0 got %h want 42", get_byte(0)); end
      checks++; if (get_byte(9) !== 8'h12) begin errors++; $display("FAIL write_byte1 got %h want 12", get_byte(9)); end
      checks++; if (get_byte(18) !== 8'h80) begin errors++; $display("FAIL write_byte2 got %h want 80", get_byte(18)); end
      checks++; if (n_start != 1 || n_stop != 1) begin errors++; $display("FAIL write_start_stop got %0d/%0d want 1/1", n_start, n_stop); end
      checks++; if (min_iv != 2 || max_iv != 2) begin errors++; $display("FAIL write_scl_period got min %0d max %0d want 2/2", min_iv, max_iv); end
      checks++; if (bit_idx != 28) begin errors++; $display("FAIL write_scl_pulses got %0d want 28", bit_idx); end
      @(posedge clk); #2;
      checks++; if (m_done !== 1'b0) begin errors++; $display("FAIL write_done_width got %b want 0", m_done); end
      $display("test_write dev=21 reg=12 data=80 ticks=%0d bytes=%h %h %h", done_ticks, get_byte(0), get_byte(9), get_byte(18));
   endtask

   task automatic test_nack();
      bit ok;
      sel = 1'b0; ack_mask = 3'b110;
      run_start(7'h21, 8'h34, 8'h56, 1'b0);
      wait_done(2000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL nack_timeout got no done want done"); end
      checks++; if (done_ticks != 42) begin errors++; $display("FAIL nack_ticks got %0d want 42", done_ticks); end
      checks++; if (m_err !== 1'b1) begin errors++; $display("FAIL nack_ack_err got %b want 1", m_err); end
      checks++; if (get_byte(0) !== 8'h42) begin errors++; $display("FAIL nack_byte0 got %h want 42", get_byte(0)); end
      checks++; if (n_stop != 1 || bit_idx != 10) begin errors++; $display("FAIL nack_stop got stops %0d pulses %0d want 1/10", n_stop, bit_idx); end
      $display("test_nack ticks=%0d ack_err=%b", done_ticks, m_err);
   endtask

   task automatic test_ignore_nack();
      bit ok;
      sel = 1'b1; ack_mask = 3'b110;
      run_start(7'h3C, 8'h34, 8'h56, 1'b0);
      wait_done(2000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ignore_timeout got no done want done"); end
      checks++; if (done_ticks != 114) begin errors++; $display("FAIL ignore_ticks got %0d want 114", done_ticks); end
      checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL ignore_ack_err got %b want 0", m_err); end
      checks++; if (get_byte(0) !== 8'h78) begin errors++; $display("FAIL ignore_byte0 got %h want 78", get_byte(0)); end
      checks++; if (get_byte(9) !== 8'h34 || get_byte(18) !== 8'h56) begin errors++; $display("FAIL ignore_bytes got %h %h want 34 56", get_byte(9), get_byte(18)); end
      $display("test_ignore_nack ticks=%0d ack_err=%b", done_ticks, m_err);
      sel = 1'b0; ack_mask = 3'b111;
      @(posedge clk); #2;
   endtask

   task automatic test_back_to_back();
      int dc0;
      int n;
      sel = 1'b0; ack_mask = 3'b111;
      checks++; if (m_err !== 1'b1) begin errors++; $display("FAIL busy_pre_ack_err got %b want 1", m_err); end
      dc0 = done_count;
      run_start(7'h55, 8'hA5, 8'h0F, 1'b0);
      checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL busy_ack_err_clear got %b want 0", m_err); end
      n = 0;
      while (tick_cnt < 20 && n < 1000) begin @(posedge clk); #2; n++; end
      // Request while busy: must be dropped, not queued.
      dev = 7'h7F; rega = 8'hFF; data = 8'hFF; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      n = 0;
      while (tick_cnt < 114 && n < 2000) begin @(posedge clk); #2; n++; end
      checks++; if (tick_cnt != 114) begin errors++; $display("FAIL busy_reach_end got %0d want 114", tick_cnt); end
      // Hold start across the done cycle: must be ignored as well.
      start = 1'b1;
      @(posedge clk); #2;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (300) @(posedge clk);
      #2;
      checks++; if (done_count - dc0 != 1) begin errors++; $display("FAIL busy_done_count got %0d want 1", done_count - dc0); end
      checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL busy_no_queue got %b want 0", m_busy); end
      checks++; if (get_byte(0) !== 8'hAA || get_byte(9) !== 8'hA5 || get_byte(18) !== 8'h0F) begin
         errors++; $display("FAIL busy_bytes got %h %h %h want aa a5 0f", get_byte(0), get_byte(9), get_byte(18));
      end
      $display("test_back_to_back transactions=%0d bytes=%h %h %h", done_count - dc0, get_byte(0), get_byte(9), get_byte(18));
   endtask

   task automatic test_reset_mid();
      int dc0;
      int n;
      sel = 1'b0; ack_mask = 3'b111;
      run_start(7'h21, 8'h12, 8'h80, 1'b0);
      n = 0;
      while (tick_cnt < 50 && n < 1000) begin @(posedge clk); #2; n++; end
      // Tick 50 is bit 2 of 0x12 (a zero), so SDA is being pulled low.
      checks++; if (m_busy !== 1'b1 || m_sda !== 1'b1) begin errors++; $display("FAIL rst_pre got busy %b sda_oe %b want 1 1", m_busy, m_sda); end
      dc0 = done_count;
      reset = 1'b1;
      #1;
      checks++; if (if0.scl_oe !== 1'b0 || if0.sda_oe !== 1'b0) begin errors++; $display("FAIL rst_lines got %b %b want 0 0", if0.scl_oe, if0.sda_oe); end
      checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", if0.busy); end
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      repeat (200) @(posedge clk);
      #2;
      checks++; if (done_count != dc0) begin errors++; $display("FAIL rst_no_done got %0d want 0", done_count - dc0); end
      checks++; if (if0.busy !== 1'b0 || if0.sda_oe !== 1'b0) begin errors++; $display("FAIL rst_idle got busy %b sda_oe %b want 0 0", if0.busy, if0.sda_oe); end
      $display("test_reset_mid done_pulses=%0d", done_count - dc0);
   endtask

   initial begin
      test_reset();
      test_write();
      test_nack();
      test_ignore_nack();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
